// File: rtl/ip_stream_format_pkg.sv
// Shared types and helpers for the receive-side IPv4 stream front-end.
// Field offsets are counted from the MSB of the beat, because byte 0 sits in the MSBs.
`timescale 1ns/1ps
package ip_stream_format_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } in_state_e;

  // Version occupies bits [DW-1 -: 4]; IHL occupies bits [DW-5 -: 4].
  localparam int VER_OFS = 1;
  localparam int IHL_OFS = 5;
  localparam int FIELD_W = 4;

  typedef struct packed {
    logic [31:0] ts_sec;
    logic [31:0] ts_nsec;
  } tracker_stats_struct;

  function automatic logic [15:0] lines_for(input logic [15:0] bytes, input logic [15:0] per_line);
    return (bytes + per_line - 16'd1) / per_line;
  endfunction

endpackage

// File: rtl/ip_stream_format_pipe_in_multi_hdr_buf.sv
// Small FIFO holding IPv4 header lines for the checksum engine.
// The head is read straight from storage flops, so a pushed entry appears the next cycle.
`timescale 1ns/1ps
module ip_hdr_line_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_val,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_push  = i_push & (r_cnt != CNT_FULL);
  assign w_pop   = i_pop & (r_cnt != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_val   = (r_cnt != '0);
  assign o_empty = (r_cnt == '0);

  // Storage, pointers and occupancy; push and pop in one cycle are both honoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      else       r_rd_ptr <= r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ip_stream_format_pipe_in_multi.sv
// IPv4 RX front-end: forwards every MAC beat to the data FIFO and copies the
// header lines (IHL-sized, options included) into a buffer drained by the checksum engine.
`timescale 1ns/1ps
module ip_stream_format_pipe_in_multi
  import ip_stream_format_pkg::*;
#(
  parameter int DATA_WIDTH     = 256,
  parameter int DATA_BYTES     = DATA_WIDTH / 8,
  parameter int KEEP_WIDTH     = DATA_BYTES,
  parameter int PADBYTES_WIDTH = $clog2(DATA_BYTES),
  parameter int MAX_HDR_BYTES  = 60,
  parameter int HDR_LINES      = (MAX_HDR_BYTES + DATA_BYTES - 1) / DATA_BYTES,
  parameter int CHKSUM_OFFSET  = 10,
  parameter int TS_WIDTH       = $bits(tracker_stats_struct),
  parameter int FIFO_WIDTH     = DATA_WIDTH + PADBYTES_WIDTH + 1 + TS_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      src_ip_format_rx_val,
  input  tracker_stats_struct       src_ip_format_rx_timestamp,
  output logic                      ip_format_src_rx_rdy,
  input  logic [DATA_WIDTH-1:0]     src_ip_format_rx_data,
  input  logic                      src_ip_format_rx_last,
  input  logic [PADBYTES_WIDTH-1:0] src_ip_format_rx_padbytes,
  output logic                      ip_chksum_cmd_val,
  output logic                      ip_chksum_cmd_enable,
  output logic [7:0]                ip_chksum_cmd_start,
  output logic [7:0]                ip_chksum_cmd_offset,
  output logic [15:0]               ip_chksum_cmd_init,
  input  logic                      ip_chksum_cmd_rdy,
  output logic [DATA_WIDTH-1:0]     ip_chksum_req_data,
  output logic [KEEP_WIDTH-1:0]     ip_chksum_req_keep,
  output logic                      ip_chksum_req_val,
  output logic                      ip_chksum_req_last,
  input  logic                      ip_chksum_req_rdy,
  output logic                      in_data_fifo_wr_req,
  output logic [FIFO_WIDTH-1:0]     in_data_fifo_wr_data,
  input  logic                      data_fifo_in_full,
  output logic                      hdr_trunc
);

  localparam int ENTRY_W = DATA_WIDTH + 1 + KEEP_WIDTH;
  localparam logic [KEEP_WIDTH-1:0] KEEP_ONES = '1;
  localparam logic [15:0] BYTES16 = 16'(DATA_BYTES);

  in_state_e           r_state;
  in_state_e           w_state_nxt;
  logic                r_run;
  logic [3:0]          r_ihl;
  logic [15:0]         r_cnt;
  logic [15:0]         w_cnt_nxt;
  logic [15:0]         w_cnt_line;
  logic [15:0]         w_hdr_len;
  logic [15:0]         w_need;
  logic [15:0]         w_rem;
  logic [3:0]          w_ver_in;
  logic [3:0]          w_ihl_in;
  logic [3:0]          w_ihl;
  logic                w_hs;
  logic                w_idle;
  logic                w_enable;
  logic                w_push;
  logic                w_final;
  logic                w_trunc;
  logic                w_buf_empty;
  logic                w_pop;
  logic [KEEP_WIDTH-1:0] w_keep_fin;
  logic [KEEP_WIDTH-1:0] w_keep;
  logic [ENTRY_W-1:0]  w_entry_in;
  logic [ENTRY_W-1:0]  w_entry_out;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_ver_in = src_ip_format_rx_data[DATA_WIDTH-VER_OFS -: FIELD_W];
  assign w_ihl_in = src_ip_format_rx_data[DATA_WIDTH-IHL_OFS -: FIELD_W];
  assign w_enable = (w_ver_in == 4'd4) && (w_ihl_in >= 4'd5);

  // r_run keeps rdy low while in reset and for the first cycle out of it.
  assign ip_format_src_rx_rdy = r_run & ~data_fifo_in_full &
                                (~w_idle | (ip_chksum_cmd_rdy & w_buf_empty));
  assign w_hs = src_ip_format_rx_val & ip_format_src_rx_rdy;

  // In IDLE the header geometry comes from the live beat, afterwards from the latched IHL.
  assign w_ihl      = w_idle ? w_ihl_in : r_ihl;
  assign w_hdr_len  = {10'd0, w_ihl, 2'b00};
  assign w_need     = lines_for(w_hdr_len, BYTES16);
  assign w_rem      = w_hdr_len % BYTES16;
  assign w_keep_fin = (w_rem == 16'd0) ? KEEP_ONES : (KEEP_ONES << (BYTES16 - w_rem));

  assign w_cnt_line = w_idle ? 16'd1 : (r_cnt + 16'd1);
  assign w_push     = w_hs & ((w_idle & w_enable) | (r_state == ST_HDR));
  assign w_final    = (w_cnt_line == w_need);
  assign w_trunc    = w_push & src_ip_format_rx_last & (w_cnt_line < w_need);
  assign w_keep     = w_trunc ? (KEEP_ONES << src_ip_format_rx_padbytes) :
                      (w_final ? w_keep_fin : KEEP_ONES);
  assign w_entry_in = {src_ip_format_rx_data, w_final | w_trunc, w_keep};

  assign ip_chksum_cmd_val    = w_hs & w_idle;
  assign ip_chksum_cmd_enable = ip_chksum_cmd_val & w_enable;
  assign ip_chksum_cmd_start  = 8'd0;
  assign ip_chksum_cmd_offset = 8'(CHKSUM_OFFSET);
  assign ip_chksum_cmd_init   = 16'd0;
  assign hdr_trunc            = w_trunc;

  assign in_data_fifo_wr_req  = w_hs;
  assign in_data_fifo_wr_data = {src_ip_format_rx_data, src_ip_format_rx_padbytes,
                                 src_ip_format_rx_last, src_ip_format_rx_timestamp};

  assign w_pop = ip_chksum_req_val & ip_chksum_req_rdy;
  assign {ip_chksum_req_data, ip_chksum_req_last, ip_chksum_req_keep} = w_entry_out;

  ip_hdr_line_buf #(
    .WIDTH (ENTRY_W),
    .DEPTH (HDR_LINES)
  ) u_hdr_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_entry_in),
    .i_pop   (w_pop),
    .o_data  (w_entry_out),
    .o_val   (ip_chksum_req_val),
    .o_empty (w_buf_empty)
  );

  // Next-state and header line count for the IDLE -> HDR -> BODY walk.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_cnt_nxt = w_enable ? 16'd1 : 16'd0;
          if (src_ip_format_rx_last)                w_state_nxt = ST_IDLE;
          else if (w_enable && (w_need > 16'd1))    w_state_nxt = ST_HDR;
          else                                      w_state_nxt = ST_BODY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (w_hs) begin
          w_cnt_nxt = w_cnt_line;
          if (src_ip_format_rx_last) w_state_nxt = ST_IDLE;
          else if (w_final)          w_state_nxt = ST_BODY;
          else                       w_state_nxt = ST_HDR;
        end else begin
          w_state_nxt = ST_HDR;
        end
      end
      ST_BODY: begin
        if (w_hs && src_ip_format_rx_last) w_state_nxt = ST_IDLE;
        else                               w_state_nxt = ST_BODY;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  // Input state, line count and the IHL latched from the first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
      r_ihl   <= 4'd0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_run   <= 1'b1;
      if (w_hs && w_idle) r_ihl <= w_ihl_in;
      else                r_ihl <= r_ihl;
    end
  end

endmodule

// File: tb/tb_ip_stream_format_pipe_in_multi.sv
// Scoreboard bench at DATA_WIDTH=128: a packet-level model queues expected FIFO writes,
// commands, header lines and truncation pulses; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_ip_stream_format_pipe_in_multi;
  import ip_stream_format_pkg::*;

  localparam int DW  = 128;
  localparam int DB  = DW / 8;
  localparam int PW  = $clog2(DB);
  localparam int TSW = $bits(tracker_stats_struct);
  localparam int FW  = DW + PW + 1 + TSW;
  localparam int EW  = DW + 1 + DB;
  localparam int BEAT_BUDGET = 500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                src_val = 1'b0;
  tracker_stats_struct src_ts = '0;
  logic                rx_rdy;
  logic [DW-1:0]       src_data = '0;
  logic                src_last = 1'b0;
  logic [PW-1:0]       src_pad = '0;
  logic                cmd_val, cmd_en;
  logic [7:0]          cmd_start, cmd_offset;
  logic [15:0]         cmd_init;
  logic                cmd_rdy = 1'b0;
  logic [DW-1:0]       req_data;
  logic [DB-1:0]       req_keep;
  logic                req_val, req_last;
  logic                req_rdy = 1'b0;
  logic                wr_req;
  logic [FW-1:0]       wr_data;
  logic                fifo_full = 1'b0;
  logic                trunc;

  int n_tests = 0;
  int n_fail  = 0;
  int full_mode = 0, rdy_mode = 1, cmd_mode = 1;   // 0 low, 1 high, 2 random

  logic [FW-1:0] exp_fifo_q [$];
  logic          exp_cmd_q [$];
  logic [EW-1:0] exp_req_q [$];
  logic [DW-1:0] exp_trunc_q [$];

  ip_stream_format_pipe_in_multi #(.DATA_WIDTH(DW)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .src_ip_format_rx_val       (src_val),
    .src_ip_format_rx_timestamp (src_ts),
    .ip_format_src_rx_rdy       (rx_rdy),
    .src_ip_format_rx_data      (src_data),
    .src_ip_format_rx_last      (src_last),
    .src_ip_format_rx_padbytes  (src_pad),
    .ip_chksum_cmd_val          (cmd_val),
    .ip_chksum_cmd_enable       (cmd_en),
    .ip_chksum_cmd_start        (cmd_start),
    .ip_chksum_cmd_offset       (cmd_offset),
    .ip_chksum_cmd_init         (cmd_init),
    .ip_chksum_cmd_rdy          (cmd_rdy),
    .ip_chksum_req_data         (req_data),
    .ip_chksum_req_keep         (req_keep),
    .ip_chksum_req_val          (req_val),
    .ip_chksum_req_last         (req_last),
    .ip_chksum_req_rdy          (req_rdy),
    .in_data_fifo_wr_req        (wr_req),
    .in_data_fifo_wr_data       (wr_data),
    .data_fifo_in_full          (fifo_full),
    .hdr_trunc                  (trunc)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic pick(input int mode, input int pct_hi);
    return (mode == 2) ? ($urandom_range(0, 99) < pct_hi) : (mode == 1);
  endfunction

  // Sink-side handshake drivers, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      fifo_full = pick(full_mode, 25);
      req_rdy   = pick(rdy_mode, 60);
      cmd_rdy   = pick(cmd_mode, 80);
    end
  end

  // Monitor: every observed transfer is matched against the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_full) check("rdy_while_full", rx_rdy, 1'b0);
      if (wr_req) begin
        if (exp_fifo_q.size() == 0) check("fifo_unexpected_write", 1'b1, 1'b0);
        else check("fifo_write", wr_data, exp_fifo_q.pop_front());
      end
      if (cmd_val) begin
        check("cmd_constants", {cmd_start, cmd_offset, cmd_init}, {8'd0, 8'd10, 16'd0});
        if (exp_cmd_q.size() == 0) check("cmd_unexpected", 1'b1, 1'b0);
        else check("cmd_enable", cmd_en, exp_cmd_q.pop_front());
      end
      if (req_val && req_rdy) begin
        if (exp_req_q.size() == 0) check("req_unexpected", 1'b1, 1'b0);
        else check("req_line", {req_data, req_last, req_keep}, exp_req_q.pop_front());
      end
      if (trunc) begin
        if (exp_trunc_q.size() == 0) check("trunc_unexpected", 1'b1, 1'b0);
        else check("hdr_trunc_beat", src_data, exp_trunc_q.pop_front());
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic [PW-1:0] pad,
                           input tracker_stats_struct ts, output int stalls);
    src_val = 1'b1; src_data = d; src_last = last; src_pad = pad; src_ts = ts;
    stalls = 0;
    @(negedge clk);
    while (!rx_rdy && stalls < BEAT_BUDGET) begin
      stalls++;
      @(negedge clk);
    end
    if (!rx_rdy) check("beat_accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    src_val = 1'b0; src_last = 1'b0;
  endtask

  // Reference model: expectations follow from packet geometry, not cycle behaviour.
  task automatic send_pkt(input int nb, input logic [3:0] ver, input logic [3:0] ihl,
                          input logic [PW-1:0] last_pad, output int stalls);
    logic [DW-1:0]       d [$];
    logic [PW-1:0]       p [$];
    tracker_stats_struct t [$];
    logic                en;
    logic [DB-1:0]       k;
    int                  need, n, valid, st;
    stalls = 0;
    for (int i = 0; i < nb; i++) begin
      logic [DW-1:0] x;
      x = {$urandom, $urandom, $urandom, $urandom};
      if (i == 0) x[DW-1 -: 8] = {ver, ihl};
      d.push_back(x);
      p.push_back((i == nb - 1) ? last_pad : PW'($urandom));
      t.push_back({$urandom, $urandom});
      exp_fifo_q.push_back({x, p[i], (i == nb - 1), t[i]});
    end
    en = (ver == 4'd4) && (ihl >= 4'd5);
    exp_cmd_q.push_back(en);
    if (en) begin
      need = (int'(ihl) * 4 + DB - 1) / DB;
      n = (nb < need) ? nb : need;
      for (int i = 0; i < n; i++) begin
        if (i < n - 1)       valid = DB;
        else if (nb < need)  valid = DB - int'(last_pad);
        else                 valid = int'(ihl) * 4 - (need - 1) * DB;
        for (int b = 0; b < DB; b++) k[DB-1-b] = (b < valid);
        exp_req_q.push_back({d[i], (i == n - 1), k});
      end
      if (nb < need) exp_trunc_q.push_back(d[nb-1]);
    end
    for (int i = 0; i < nb; i++) begin
      send_beat(d[i], (i == nb - 1), p[i], t[i], st);
      stalls += st;
    end
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_fifo_q.size() + exp_cmd_q.size() + exp_req_q.size() + exp_trunc_q.size()) != 0
           && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("drain_within_budget", (c < 2000), 1'b1);
  endtask

  initial begin
    int st;
    logic [DW-1:0] h;
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", {rx_rdy, cmd_val, cmd_en, req_val, req_last, req_keep, wr_req, trunc}, '0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Basic header geometries with all readies high
    send_pkt(4, 4'd4, 4'd5, 4'd0, st);
    send_pkt(3, 4'd4, 4'd15, 4'd0, st);
    send_pkt(2, 4'd4, 4'd8, 4'd3, st);
    send_pkt(3, 4'd6, 4'd5, 4'd0, st);
    send_pkt(2, 4'd4, 4'd3, 4'd0, st);
    send_pkt(2, 4'd4, 4'd15, 4'd4, st);
    send_pkt(1, 4'd4, 4'd15, 4'd9, st);
    drain();

    // Engine stalled: header beats must not hold up the MAC stream
    rdy_mode = 0;
    @(posedge clk); #1;
    send_pkt(6, 4'd4, 4'd15, 4'd2, st);
    check("no_stall_with_engine_blocked", st, 0);
    fork
      begin
        repeat (3) @(negedge clk);
        check("next_pkt_waits_for_drain", rx_rdy, 1'b0);
        rdy_mode = 1;
      end
    join_none
    send_pkt(2, 4'd4, 4'd5, 4'd1, st);
    check("next_pkt_waited", (st > 0), 1'b1);
    drain();

    // Reset in the middle of a header
    rdy_mode = 0;
    @(posedge clk); #1;
    h = {$urandom, $urandom, $urandom, $urandom};
    h[DW-1 -: 8] = 8'h4F;
    exp_cmd_q.push_back(1'b1);
    exp_fifo_q.push_back({h, 4'd0, 1'b0, 64'd7});
    send_beat(h, 1'b0, 4'd0, 64'd7, st);
    exp_fifo_q.push_back({~h, 4'd0, 1'b0, 64'd8});
    send_beat(~h, 1'b0, 4'd0, 64'd8, st);
    src_val = 1'b1; src_data = h ^ {DW{1'b1}}; src_last = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {rx_rdy, cmd_val, cmd_en, req_val, req_last, req_keep, wr_req, trunc}, '0);
    check("reset_fifo_expectations_met", exp_fifo_q.size(), 0);
    src_val = 1'b0;
    rdy_mode = 1;
    repeat (2) @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("buffer_cleared_by_reset", req_val, 1'b0);
    @(posedge clk); #1;

    // Randomized traffic with random back-pressure everywhere
    full_mode = 2; rdy_mode = 2; cmd_mode = 2;
    for (int i = 0; i < 60; i++) begin
      send_pkt($urandom_range(1, 6), ($urandom_range(0, 7) == 0) ? 4'd6 : 4'd4,
               4'($urandom_range(0, 15)), PW'($urandom), st);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    full_mode = 0; rdy_mode = 1; cmd_mode = 1;
    drain();
    check("fifo_q_empty", exp_fifo_q.size(), 0);
    check("cmd_q_empty", exp_cmd_q.size(), 0);
    check("req_q_empty", exp_req_q.size(), 0);
    check("trunc_q_empty", exp_trunc_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
